// File: rtl/iic_cfg_seq.sv
// ---------------------------------------------------------------------------
// iic_cfg_seq
// Register-configuration sequencer for the IIC write engine (iic_send).
// Walks a table of {word address, data} pairs held in an external
// synchronous ROM. It starts after a power-up delay, or on request. For each
// entry it raises the engine enable and holds it until the engine's done
// pulse. It then drops the enable, waits a gap and moves to the next entry.
// A transfer with no done pulse is retried a bounded number of times. The
// sequencer reports overall completion or failure to system control.
//
// Ports
//   I_clk          system clock
//   I_rst_n        asynchronous, active-low reset
//   I_start        one-cycle restart request; honoured in IDLE, DONE, ERR
//   O_rom_addr     table index presented to the ROM
//   I_rom_data     {word_addr, data}; valid one cycle after O_rom_addr
//   O_iic_send_en  enable to the write engine
//   O_dev_addr     7-bit IIC device address (constant)
//   O_word_addr    register address of the current entry
//   O_write_data   data byte of the current entry
//   I_done_flag    one-cycle done pulse from the write engine
//   O_busy         high while a configuration pass is in progress
//   O_cfg_done     level: table completed successfully
//   O_cfg_err      level: retries exhausted on one entry
//   O_err_index    index of the failing entry while O_cfg_err is high
// ---------------------------------------------------------------------------
module iic_cfg_seq #(
   parameter logic [6:0]  C_DEV_ADDR  = 7'h3C,
   parameter int unsigned C_REG_NUM   = 16,
   parameter int unsigned C_PWR_DLY   = 1_000_000,
   parameter int unsigned C_TIMEOUT   = 50_000,
   parameter int unsigned C_MAX_RETRY = 3,
   parameter int unsigned C_GAP       = 100
) (
   input  logic        I_clk,
   input  logic        I_rst_n,
   input  logic        I_start,
   output logic [7:0]  O_rom_addr,
   input  logic [15:0] I_rom_data,
   output logic        O_iic_send_en,
   output logic [6:0]  O_dev_addr,
   output logic [7:0]  O_word_addr,
   output logic [7:0]  O_write_data,
   input  logic        I_done_flag,
   output logic        O_busy,
   output logic        O_cfg_done,
   output logic        O_cfg_err,
   output logic [7:0]  O_err_index
);

   typedef enum logic [3:0] {
      ST_PWR_WAIT = 4'd0,
      ST_IDLE     = 4'd1,
      ST_ROM_REQ  = 4'd2,
      ST_ROM_WAIT = 4'd3,
      ST_LOAD     = 4'd4,
      ST_SEND     = 4'd5,
      ST_GAP      = 4'd6,
      ST_DONE     = 4'd7,
      ST_ERR      = 4'd8
   } state_t;

   // The delay counter counts from 0, so each terminal value is length-1.
   localparam logic [23:0] LP_PWR_LAST  = (C_PWR_DLY == 0) ? 24'd0 : 24'(C_PWR_DLY - 1);
   localparam logic [23:0] LP_TO_LAST   = 24'(C_TIMEOUT - 1);
   localparam logic [23:0] LP_GAP_LAST  = 24'(C_GAP - 1);
   localparam logic [3:0]  LP_RETRY_MAX = 4'(C_MAX_RETRY);
   localparam logic [7:0]  LP_LAST_IDX  = 8'(C_REG_NUM - 1);
   // Without a power-up delay, the sequencer parks in IDLE and waits for I_start.
   localparam state_t      LP_RST_STATE = (C_PWR_DLY == 0) ? ST_IDLE : ST_PWR_WAIT;

   state_t      r_state;
   state_t      w_next;
   logic [23:0] r_cnt;
   logic [7:0]  r_index;
   logic [3:0]  r_retry;
   logic [7:0]  r_word;
   logic [7:0]  r_data;
   logic        r_en;
   logic        r_done;
   logic        r_err;
   logic [7:0]  r_err_idx;

   logic        w_marker;
   logic        w_last;
   logic        w_idle_like;
   logic        w_restart;
   logic        w_ack;
   logic        w_timeout;
   logic        w_load;
   logic [3:0]  w_retry_inc;

   assign w_marker    = (I_rom_data == 16'hFFFF);
   assign w_last      = (r_index == LP_LAST_IDX);
   assign w_idle_like = (r_state == ST_IDLE) || (r_state == ST_DONE) || (r_state == ST_ERR);
   assign w_restart   = I_start && w_idle_like;
   assign w_ack       = (r_state == ST_SEND) && I_done_flag;
   // A done pulse on the terminal count wins over the timeout.
   assign w_timeout   = (r_state == ST_SEND) && !I_done_flag && (r_cnt == LP_TO_LAST);
   assign w_load      = (r_state == ST_LOAD) && !w_marker;
   assign w_retry_inc = r_retry + 4'd1;

   // State register.
   always_ff @(posedge I_clk or negedge I_rst_n) begin
      if (!I_rst_n) begin
         r_state <= LP_RST_STATE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state logic for the table walk.
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_PWR_WAIT: if (r_cnt == LP_PWR_LAST) w_next = ST_ROM_REQ;
         ST_IDLE:     if (I_start) w_next = ST_ROM_REQ;
         ST_ROM_REQ:  w_next = ST_ROM_WAIT;
         ST_ROM_WAIT: w_next = ST_LOAD;
         ST_LOAD:     w_next = w_marker ? ST_DONE : ST_SEND;
         ST_SEND: begin
            if (I_done_flag) begin
               w_next = w_last ? ST_DONE : ST_GAP;
            end else if (r_cnt == LP_TO_LAST) begin
               w_next = (w_retry_inc == LP_RETRY_MAX) ? ST_ERR : ST_GAP;
            end
         end
         ST_GAP:      if (r_cnt == LP_GAP_LAST) w_next = ST_ROM_REQ;
         ST_DONE:     if (I_start) w_next = ST_ROM_REQ;
         ST_ERR:      if (I_start) w_next = ST_ROM_REQ;
         default:     w_next = LP_RST_STATE;
      endcase
   end

   // One shared delay counter for power-up, timeout and gap.
   // It restarts from zero on every state change.
   always_ff @(posedge I_clk or negedge I_rst_n) begin
      if (!I_rst_n) begin
         r_cnt <= 24'd0;
      end else if (w_next != r_state) begin
         r_cnt <= 24'd0;
      end else begin
         r_cnt <= r_cnt + 24'd1;
      end
   end

   // Table index and retry bookkeeping. On the final entry the index holds
   // instead of stepping past the table, so it never wraps.
   always_ff @(posedge I_clk or negedge I_rst_n) begin
      if (!I_rst_n) begin
         r_index <= 8'd0;
         r_retry <= 4'd0;
      end else if (w_restart) begin
         r_index <= 8'd0;
         r_retry <= 4'd0;
      end else if (w_ack) begin
         r_retry <= 4'd0;
         if (!w_last) begin
            r_index <= r_index + 8'd1;
         end
      end else if (w_timeout) begin
         r_retry <= w_retry_inc;
      end
   end

   // Entry payload is captured only in LOAD.
   // That keeps it stable for the whole enable window.
   always_ff @(posedge I_clk or negedge I_rst_n) begin
      if (!I_rst_n) begin
         r_word <= 8'd0;
         r_data <= 8'd0;
      end else if (w_load) begin
         r_word <= I_rom_data[15:8];
         r_data <= I_rom_data[7:0];
      end
   end

   // Registered status outputs are decoded from the next state.
   // They change on the same edge as the state they describe.
   always_ff @(posedge I_clk or negedge I_rst_n) begin
      if (!I_rst_n) begin
         r_en      <= 1'b0;
         r_done    <= 1'b0;
         r_err     <= 1'b0;
         r_err_idx <= 8'd0;
      end else begin
         r_en   <= (w_next == ST_SEND);
         r_done <= (w_next == ST_DONE);
         r_err  <= (w_next == ST_ERR);
         if (w_restart) begin
            r_err_idx <= 8'd0;
         end else if ((w_next == ST_ERR) && (r_state != ST_ERR)) begin
            r_err_idx <= r_index;
         end
      end
   end

   assign O_rom_addr    = r_index;
   assign O_iic_send_en = r_en;
   assign O_dev_addr    = C_DEV_ADDR;
   assign O_word_addr   = r_word;
   assign O_write_data  = r_data;
   assign O_busy        = !w_idle_like;
   assign O_cfg_done    = r_done;
   assign O_cfg_err     = r_err;
   assign O_err_index   = r_err_idx;

endmodule
